vga_frame_capture: RTL and testbench
====================================

Name: vga_frame_capture

Overview:
- Sink-side decoder for the SoC VGA output (vga_hs, vga_vs, vga_color), running on the VGA pixel clock domain.
- Recovers pixel coordinates from the sync pulses and streams each active pixel out with its x/y.
- Accumulates a per-frame signature and counts frames.
- Flags line-period and short-frame timing errors, so benches and on-chip self-test can check rendered output without a monitor.

Parameters:
- BPP, 3, colour bits per pixel.
- SYNC_POL, 0, active level of both hs and vs (0 = active-low).
- H_TOTAL, 800, expected clocks between hsync leading edges.
- H_START, 144, clocks from hsync leading edge to first active pixel.
- H_ACTIVE, 640, active pixels per line.
- V_START, 35, hsync edges after vsync leading edge before first active line.
- V_ACTIVE, 480, active lines per frame.
- WIDTH_X, 10, width of x/hcount.
- WIDTH_Y, 10, width of y/vcount.

Ports:
- clk  in  1  pixel clock (clkv domain)
- reset  in  1  synchronous reset, active-low
- vga_hs  in  1  horizontal sync
- vga_vs  in  1  vertical sync
- vga_color  in  BPP  pixel colour
- pix_valid  out  1  active pixel strobe
- pix_x  out  WIDTH_X  active-area column, 0-based
- pix_y  out  WIDTH_Y  active-area row, 0-based
- pix_color  out  BPP  captured colour
- frame_done  out  1  one-cycle pulse at end of last active line
- frame_sig  out  32  signature of last completed frame
- frame_count  out  16  completed frames, wraps at 0xFFFF->0
- err_hlen  out  1  sticky: measured line period != H_TOTAL
- err_vshort  out  1  sticky: vsync edge arrived before frame completed

Behaviour:
- Reset (reset==0 at clk edge):
  - All outputs 0.
  - Counters 0.
  - State WAIT_VSYNC.
  - Input registers loaded with the inactive sync level.
  - The first line period after reset is not checked.
- Input stage:
  - hs/vs/color are registered once (stage s1).
  - A leading edge is s1 active while the previous s1 was inactive.
  - All decoding uses s1.
- hcount:
  - Cleared to 0 on the cycle an hs leading edge is seen; otherwise increments, saturating at all-ones.
  - On an hs edge with measurement armed, if hcount+1 != H_TOTAL then err_hlen is set.
  - Measurement arms after the first hs edge following reset.
- States:
  - WAIT_VSYNC: on a vs edge, go to FRAME, vcount=0, signature=0.
  - FRAME:
    - Each hs edge increments vcount.
    - A vs edge sets err_vshort, restarts the frame (vcount=0, signature=0) and does not pulse frame_done.
    - If hs and vs edges coincide, the vs action wins and vcount=0.
- Active pixel condition:
  - State is FRAME.
  - H_START <= hcount < H_START+H_ACTIVE.
  - V_START <= vcount < V_START+V_ACTIVE.
  - The hs edge cycle itself counts as hcount=0.
- Active pixel outputs:
  - pix_valid is registered and asserted 2 clocks after the pixel is present on the input pins.
  - pix_x = hcount-H_START, pix_y = vcount-V_START, pix_color = s1 colour.
  - pix_x/pix_y/pix_color hold their last value when pix_valid=0.
- Signature:
  - Per active pixel: sig <= {sig[30:0],sig[31]} ^ zero-extended colour.
- End of frame:
  - Triggered by the hs edge that makes vcount == V_START+V_ACTIVE.
  - frame_sig <= sig, including any pixel accumulated that same cycle.
  - frame_done pulses 1 clk, coincident with the frame_sig update.
  - frame_count increments.
  - State returns to WAIT_VSYNC.
- Error flags: err_hlen and err_vshort are cleared only by reset.
- Reset mid-frame: the partial frame is discarded and frame_sig stays 0.

Test Plan (small config: H_TOTAL=20, H_START=4, H_ACTIVE=8, V_START=2, V_ACTIVE=3, BPP=3, active-low sync):
1. Nominal frame, colour=(x+y)&7 -> 24 pix_valid pulses, (x,y) raster order 0..7 x 0..2, each 2 clks after the pins. frame_done once; frame_count=1; frame_sig equals the bench model of the rotate-xor; err flags 0.
2. Two back-to-back identical frames -> frame_count=2, same frame_sig both times. Hold reset low for 3 clks mid-frame-3 -> all outputs 0, no frame_done until the next full frame.
3. One line stretched to 21 clks -> err_hlen=1, stays 1 through later good lines. Pixel stream continues with correct x for the following lines.
4. vsync edge after only 1 active line -> err_vshort=1, no frame_done, 8 partial pixels emitted. The next full frame completes with the correct signature and frame_count=1.
5. hs and vs leading edges on the same clock -> vcount=0; first active line is the 2nd hs edge after it; pix_y starts at 0.
6. Preset frame_count to 0xFFFF via 65535 short frames (or force) -> next frame_done wraps it to 0.

Source files
------------

// File: rtl/vga_frame_capture.sv
// Decodes VGA hs/vs/colour into a raster-addressed pixel stream and keeps a per-frame signature, a frame count and timing error flags.
// Latency: pix_valid and frame_done follow the pins by 2 clk. There is no backpressure; the stream runs at the pixel clock.
module vga_frame_capture #(
    parameter int BPP      = 3,
    parameter int SYNC_POL = 0,
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter int WIDTH_X  = 10,
    parameter int WIDTH_Y  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vga_hs,
    input  logic               vga_vs,
    input  logic [BPP-1:0]     vga_color,
    output logic               pix_valid,
    output logic [WIDTH_X-1:0] pix_x,
    output logic [WIDTH_Y-1:0] pix_y,
    output logic [BPP-1:0]     pix_color,
    output logic               frame_done,
    output logic [31:0]        frame_sig,
    output logic [15:0]        frame_count,
    output logic               err_hlen,
    output logic               err_vshort
);

    localparam logic             ACT   = (SYNC_POL != 0);
    localparam logic [WIDTH_X:0] H_LEN = (WIDTH_X+1)'(H_TOTAL);
    localparam logic [WIDTH_X:0] H_LO  = (WIDTH_X+1)'(H_START);
    localparam logic [WIDTH_X:0] H_HI  = (WIDTH_X+1)'(H_START + H_ACTIVE);
    localparam logic [WIDTH_Y:0] V_LO  = (WIDTH_Y+1)'(V_START);
    localparam logic [WIDTH_Y:0] V_HI  = (WIDTH_Y+1)'(V_START + V_ACTIVE);

    typedef enum logic {WAIT_VSYNC, FRAME} state_t;

    state_t             state;
    logic               hs_s1, vs_s1, hs_d, vs_d;
    logic [BPP-1:0]     col_s1;
    logic [WIDTH_X-1:0] hcount, h_cur;
    logic [WIDTH_Y-1:0] vcount, v_cur;
    logic [WIDTH_X:0]   h_len;
    logic [31:0]        sig, sig_next;
    logic               hs_edge, vs_edge, active, frame_end, armed;

    assign hs_edge = (hs_s1 == ACT) && (hs_d != ACT);
    assign vs_edge = (vs_s1 == ACT) && (vs_d != ACT);
    assign h_len   = {1'b0, hcount} + 1'b1;

    // h_cur/v_cur are the coordinates of the pixel currently in s1, so the
    // hs edge cycle itself is column 0.
    always_comb begin
        h_cur = hs_edge ? '0 : ((&hcount) ? hcount : hcount + 1'b1);
        v_cur = vcount;
        if (vs_edge)
            v_cur = '0;
        else if (state == FRAME && hs_edge)
            v_cur = vcount + 1'b1;
    end

    assign active = (state == FRAME)
                 && ({1'b0, h_cur} >= H_LO) && ({1'b0, h_cur} < H_HI)
                 && ({1'b0, v_cur} >= V_LO) && ({1'b0, v_cur} < V_HI);

    assign sig_next  = active ? ({sig[30:0], sig[31]} ^ 32'(col_s1)) : sig;
    assign frame_end = (state == FRAME) && hs_edge && !vs_edge && ({1'b0, v_cur} == V_HI);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= WAIT_VSYNC;
            hs_s1       <= ~ACT;
            vs_s1       <= ~ACT;
            hs_d        <= ~ACT;
            vs_d        <= ~ACT;
            col_s1      <= '0;
            hcount      <= '0;
            vcount      <= '0;
            sig         <= '0;
            armed       <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_color   <= '0;
            frame_done  <= 1'b0;
            frame_sig   <= '0;
            frame_count <= '0;
            err_hlen    <= 1'b0;
            err_vshort  <= 1'b0;
        end else begin
            hs_s1  <= vga_hs;
            vs_s1  <= vga_vs;
            col_s1 <= vga_color;
            hs_d   <= hs_s1;
            vs_d   <= vs_s1;
            hcount <= h_cur;
            vcount <= v_cur;
            sig    <= sig_next;

            // The line ending at the first hs edge after reset has no start, so it is not measured.
            if (hs_edge) begin
                armed <= 1'b1;
                if (armed && h_len != H_LEN)
                    err_hlen <= 1'b1;
            end

            pix_valid <= active;
            if (active) begin
                pix_x     <= h_cur - H_LO[WIDTH_X-1:0];
                pix_y     <= v_cur - V_LO[WIDTH_Y-1:0];
                pix_color <= col_s1;
            end

            frame_done <= 1'b0;
            case (state)
                WAIT_VSYNC: begin
                    if (vs_edge) begin
                        state <= FRAME;
                        sig   <= '0;
                    end
                end
                FRAME: begin
                    if (vs_edge) begin
                        err_vshort <= 1'b1;
                        sig        <= '0;
                    end else if (frame_end) begin
                        frame_sig   <= sig_next;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                        state       <= WAIT_VSYNC;
                    end
                end
                default: state <= WAIT_VSYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a small raster (20 clk lines, 8x3 active window) with a line-level reference model.
module tb_vga_frame_capture;

    localparam int HT = 20, HS = 4, HA = 8, VS = 2, VA = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vga_hs = 1'b1, vga_vs = 1'b1;
    logic [2:0]  vga_color = '0;
    logic        pix_valid, frame_done, err_hlen, err_vshort;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  pix_color;
    logic [31:0] frame_sig;
    logic [15:0] frame_count;

    vga_frame_capture #(
        .BPP(3), .SYNC_POL(0), .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
        .V_START(VS), .V_ACTIVE(VA), .WIDTH_X(10), .WIDTH_Y(10)
    ) dut (
        .clk(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_color(vga_color),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_done(frame_done), .frame_sig(frame_sig), .frame_count(frame_count),
        .err_hlen(err_hlen), .err_vshort(err_vshort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0, dut_pix = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { int t; int x; int y; int c; } pix_t;
    typedef struct { int t; logic [31:0] sig; logic [15:0] cnt; } done_t;
    pix_t  pq[$];
    done_t dq[$];
    pix_t  pm;
    done_t dm;

    // Reference model state, advanced a pin-cycle at a time by drive_line.
    bit          m_in_frame, m_armed, m_hlen, m_vshort, pat;
    int          m_v, m_prev_len;
    logic [31:0] m_sig;
    logic [15:0] m_cnt;

    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].t < cyc) begin
            pm = pq.pop_front();
            errors++; checks++;
            $display("FAIL pix_missing: got no pixel at cycle %0d, expected x=%0d y=%0d", pm.t, pm.x, pm.y);
        end
        if (pix_valid) begin
            dut_pix++;
            if (pq.size() == 0) begin
                errors++; checks++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d at cycle %0d, expected none", pix_x, pix_y, cyc);
            end else begin
                pm = pq.pop_front();
                chk("pix_time", cyc, pm.t);
                chk("pix_x", 32'(pix_x), pm.x);
                chk("pix_y", 32'(pix_y), pm.y);
                chk("pix_color", 32'(pix_color), pm.c);
            end
        end
        while (dq.size() > 0 && dq[0].t < cyc) begin
            dm = dq.pop_front();
            errors++; checks++;
            $display("FAIL done_missing: got no frame_done at cycle %0d, expected one", dm.t);
        end
        if (frame_done) begin
            if (dq.size() == 0) begin
                errors++; checks++;
                $display("FAIL done_unexpected: got frame_done at cycle %0d, expected none", cyc);
            end else begin
                dm = dq.pop_front();
                chk("done_time", cyc, dm.t);
                chk("frame_sig", frame_sig, dm.sig);
                chk("frame_count", 32'(frame_count), 32'(dm.cnt));
            end
        end
    end

    // One line of len clocks; hs low for 2 clocks; vs goes low at vs_off (-1: no vsync).
    task automatic drive_line(int len, int vs_off);
        int col;
        bit was_in;
        for (int h = 0; h < len; h++) begin
            @(posedge clk); #1;
            vga_hs = (h < 2) ? 1'b0 : 1'b1;
            vga_vs = (vs_off >= 0 && h >= vs_off) ? 1'b0 : 1'b1;
            if (h == 0) begin
                if (m_armed && m_prev_len != HT) m_hlen = 1;
                m_armed = 1;
            end
            was_in = m_in_frame;
            if (h == vs_off) begin
                if (m_in_frame) m_vshort = 1;
                m_in_frame = 1; m_v = 0; m_sig = 0;
            end else if (h == 0 && m_in_frame) begin
                m_v++;
                if (m_v == VS + VA) begin
                    m_cnt++;
                    dq.push_back('{cyc + 2, m_sig, m_cnt});
                    m_in_frame = 0;
                end
            end
            col = pat ? ((h - HS + m_v - VS) & 7) : int'($urandom_range(0, 7));
            vga_color = 3'(col);
            if (was_in && h >= HS && h < HS + HA && m_v >= VS && m_v < VS + VA) begin
                m_sig = {m_sig[30:0], m_sig[31]} ^ 32'(col);
                pq.push_back('{cyc + 2, h - HS, m_v - VS, col});
            end
        end
        m_prev_len = len;
    endtask

    task automatic drive_frame(int nlines, int vs_off, int stretch);
        for (int l = 0; l < nlines; l++)
            drive_line((l == stretch) ? HT + 1 : HT, (l == 0) ? vs_off : -1);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vga_hs = 1'b1; vga_vs = 1'b1;
        end
        m_prev_len += n;
    endtask

    task automatic do_reset(int n);
        @(posedge clk); #1;
        reset = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1;
        @(posedge clk); #1;
        pq.delete(); dq.delete();
        m_in_frame = 0; m_armed = 0; m_hlen = 0; m_vshort = 0;
        m_v = 0; m_prev_len = 0; m_sig = 0; m_cnt = 0;
        repeat (n - 1) @(posedge clk);
        #1;
        chk("rst_pix", {9'd0, pix_valid, pix_x, pix_y, pix_color}, 32'd0);
        chk("rst_sig", frame_sig, 32'd0);
        chk("rst_flags", {13'd0, frame_done, frame_count, err_hlen, err_vshort}, 32'd0);
        reset = 1'b1;
    endtask

    typedef struct {
        int nfr; int stretch; bit short_first; int vs_off; bit pat;
        int exp_cnt; bit exp_hlen; bit exp_vshort; int exp_pix;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int base;
        tbl[0] = '{1, -1, 0, 7, 1, 1, 0, 0, 24};  // nominal, (x+y)&7
        tbl[1] = '{2, -1, 0, 7, 1, 2, 0, 0, 48};  // back-to-back frames
        tbl[2] = '{2,  3, 0, 7, 0, 2, 1, 0, 48};  // one 21-clock line
        tbl[3] = '{1, -1, 1, 0, 0, 1, 0, 1, 32};  // vsync after one active line
        tbl[4] = '{1, -1, 0, 0, 0, 1, 0, 0, 24};  // hs and vs edges together

        for (int r = 0; r < 5; r++) begin
            do_reset(3);
            pat  = tbl[r].pat;
            base = dut_pix;
            if (tbl[r].short_first) drive_frame(3, tbl[r].vs_off, -1);
            for (int f = 0; f < tbl[r].nfr; f++)
                drive_frame(6, tbl[r].vs_off, (f == 0) ? tbl[r].stretch : -1);
            idle(6);
            chk($sformatf("row%0d_count", r), 32'(frame_count), tbl[r].exp_cnt);
            chk($sformatf("row%0d_hlen", r), 32'(err_hlen), 32'(tbl[r].exp_hlen));
            chk($sformatf("row%0d_vshort", r), 32'(err_vshort), 32'(tbl[r].exp_vshort));
            chk($sformatf("row%0d_npix", r), dut_pix - base, tbl[r].exp_pix);
        end

        // Reset during the third frame: partial frame discarded, nothing until a full new frame.
        do_reset(3);
        pat = 1;
        drive_frame(6, 7, -1);
        drive_frame(6, 7, -1);
        drive_line(HT, 7);
        drive_line(HT, -1);
        drive_line(HT, -1);
        do_reset(3);
        idle(10);
        for (int l = 0; l < 6; l++) drive_line(HT, -1);
        chk("midrst_sig", frame_sig, 32'd0);
        chk("midrst_count", 32'(frame_count), 32'd0);
        drive_frame(6, 7, -1);
        idle(6);
        chk("midrst_next_count", 32'(frame_count), 32'd1);

        // frame_count wrap
        @(posedge clk); #1;
        force dut.frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_count;
        m_cnt = 16'hFFFF;
        @(posedge clk); #1;
        chk("preset_count", 32'(frame_count), 32'h0000FFFF);
        pat = 0;
        drive_frame(6, 7, -1);
        idle(6);
        chk("wrap_count", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
